// File: rtl/game_pkg.sv
// Shared definitions for the 4-dog game core.
// - Box and pair counts, and the default box dimensions (also used by game_core).
// - Pair-index tables that map a pair number p = 0..5 to its (lower, higher) box indices.
// - Collision scheduler state encoding.
package game_pkg;

    localparam int unsigned NUM_BOXES = 4;
    localparam int unsigned NUM_PAIRS = 6;

    localparam int unsigned BOX_W_DEFAULT = 48;
    localparam int unsigned BOX_H_DEFAULT = 32;

    // Pair order: (0,1) (0,2) (0,3) (1,2) (1,3) (2,3)
    localparam logic [1:0] PAIR_A [NUM_PAIRS] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    localparam logic [1:0] PAIR_B [NUM_PAIRS] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

    typedef enum logic [1:0] {
        StIdle,
        StTest,
        StEmit,
        StDone
    } sched_state_e;

endpackage

// File: rtl/box_overlap.sv
// Purely combinational inclusive AABB overlap test between two boxes of size BOX_W x BOX_H.
// Ports:
//   ax, ay   : position of box A (10-bit X, 9-bit Y, unsigned)
//   bx, by   : position of box B
//   overlap  : 1 when the boxes touch or intersect (edges sharing a coordinate count as a hit)
module box_overlap #(
    parameter int unsigned BOX_W = 48,
    parameter int unsigned BOX_H = 32
) (
    input  logic [9:0] ax,
    input  logic [8:0] ay,
    input  logic [9:0] bx,
    input  logic [8:0] by,
    output logic       overlap
);

    // All arithmetic is 11 bits so right/bottom edges never wrap.
    logic [10:0] ax_l, ax_r, bx_l, bx_r;
    logic [10:0] ay_t, ay_b, by_t, by_b;

    assign ax_l = {1'b0, ax};
    assign bx_l = {1'b0, bx};
    assign ay_t = {2'b00, ay};
    assign by_t = {2'b00, by};

    assign ax_r = ax_l + 11'(BOX_W);
    assign bx_r = bx_l + 11'(BOX_W);
    assign ay_b = ay_t + 11'(BOX_H);
    assign by_b = by_t + 11'(BOX_H);

    assign overlap = !((ax_r < bx_l) || (ax_l > bx_r) || (ay_b < by_t) || (ay_t > by_b));

endmodule

// File: rtl/collision_pair_scheduler.sv
// Frame-rate collision sequencer: on frame_tick it snapshots the four box positions and walks
// the six unordered pairs through one shared box_overlap checker. Hits on pairs whose cooldown
// is zero are accepted, start that pair's cooldown, and are emitted one at a time over a
// valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   frame_tick          : one-cycle frame-start pulse (ignored unless idle)
//   pos_x, pos_y        : packed box positions, box i at [10i+9:10i] / [9i+8:9i]
//   hit_valid/hit_ready : hit handshake; hit_a < hit_b are the box indices of the pair
//   busy                : scan in progress
//   done                : one-cycle pulse in the scan's final cycle
//   overrun             : sticky, frame_tick seen while not idle; cleared only by reset
module collision_pair_scheduler
    import game_pkg::*;
#(
    parameter int unsigned BOX_W    = BOX_W_DEFAULT,
    parameter int unsigned BOX_H    = BOX_H_DEFAULT,
    parameter int unsigned COOLDOWN = 5,
    parameter int unsigned CD_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [39:0] pos_x,
    input  logic [35:0] pos_y,
    output logic        hit_valid,
    input  logic        hit_ready,
    output logic [1:0]  hit_a,
    output logic [1:0]  hit_b,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [2:0] LAST_PAIR = 3'(NUM_PAIRS - 1);

    sched_state_e           state;
    logic [2:0]             p;
    logic [CD_W-1:0]        cd [NUM_PAIRS];
    logic [NUM_PAIRS-1:0]   loaded;
    logic [39:0]            snap_x;
    logic [35:0]            snap_y;

    logic [9:0]             sx [NUM_BOXES];
    logic [8:0]             sy [NUM_BOXES];
    logic [1:0]             ia, ib;
    logic                   overlap;

    // Operand mux: pick the two boxes of pair p out of the snapshot.
    always_comb begin
        for (int i = 0; i < NUM_BOXES; i++) begin
            sx[i] = snap_x[10*i +: 10];
            sy[i] = snap_y[9*i +: 9];
        end
        ia = PAIR_A[p];
        ib = PAIR_B[p];
    end

    box_overlap #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_box_overlap (
        .ax      (sx[ia]),
        .ay      (sy[ia]),
        .bx      (sx[ib]),
        .by      (sy[ib]),
        .overlap (overlap)
    );

    // Status outputs are decoded straight from the state register.
    assign busy      = (state != StIdle);
    assign hit_valid = (state == StEmit);
    assign done      = (state == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            p       <= '0;
            loaded  <= '0;
            snap_x  <= '0;
            snap_y  <= '0;
            hit_a   <= '0;
            hit_b   <= '0;
            overrun <= 1'b0;
            for (int k = 0; k < NUM_PAIRS; k++) begin
                cd[k] <= '0;
            end
        end else begin
            // A tick outside IDLE (including the DONE cycle) is dropped, not queued.
            if (frame_tick && (state != StIdle)) begin
                overrun <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (frame_tick) begin
                        snap_x <= pos_x;
                        snap_y <= pos_y;
                        p      <= '0;
                        state  <= StTest;
                    end
                end

                StTest: begin
                    if (overlap && (cd[p] == '0)) begin
                        cd[p]     <= CD_W'(COOLDOWN);
                        loaded[p] <= 1'b1;
                        hit_a     <= ia;
                        hit_b     <= ib;
                        state     <= StEmit;
                    end else if (p == LAST_PAIR) begin
                        state <= StDone;
                    end else begin
                        p <= p + 3'd1;
                    end
                end

                StEmit: begin
                    if (hit_ready) begin
                        if (p == LAST_PAIR) begin
                            state <= StDone;
                        end else begin
                            p     <= p + 3'd1;
                            state <= StTest;
                        end
                    end
                end

                StDone: begin
                    // Counters loaded this frame keep their full value so suppression
                    // covers exactly the next COOLDOWN frames.
                    for (int k = 0; k < NUM_PAIRS; k++) begin
                        if ((cd[k] != '0) && !loaded[k]) begin
                            cd[k] <= cd[k] - CD_W'(1);
                        end
                    end
                    loaded <= '0;
                    state  <= StIdle;
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Self-checking bench for collision_pair_scheduler: table of single-frame vectors plus
// hand-written sequences for cooldown, backpressure, overrun and mid-scan reset.
module tb_collision_pair_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic [39:0] pos_x;
    logic [35:0] pos_y;
    logic        hit_valid;
    logic        hit_ready;
    logic [1:0]  hit_a;
    logic [1:0]  hit_b;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    collision_pair_scheduler #(
        .BOX_W    (48),
        .BOX_H    (32),
        .COOLDOWN (5),
        .CD_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_a      (hit_a),
        .hit_b      (hit_b),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] x;
        logic [35:0] y;
        logic [5:0]  mask;
        int          hits;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int pair_idx(input int a, input int b);
        if (a == 0) return b - 1;
        if (a == 1) return b + 1;
        return 5;
    endfunction

    function automatic logic [39:0] px(input int x0, input int x1, input int x2, input int x3);
        return {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
    endfunction

    function automatic logic [35:0] py(input int y0, input int y1, input int y2, input int y3);
        return {9'(y3), 9'(y2), 9'(y1), 9'(y0)};
    endfunction

    task automatic set_vec(input int i, input logic [39:0] x, input logic [35:0] y,
                           input logic [5:0] mask, input int hits);
        vecs[i].x    = x;
        vecs[i].y    = y;
        vecs[i].mask = mask;
        vecs[i].hits = hits;
    endtask

    task automatic do_reset();
        frame_tick = 1'b0;
        hit_ready  = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame with hit_ready held high. Cycle 1 is the cycle after the tick edge.
    task automatic run_frame(output logic [5:0] mask, output int nhits, output int first_v,
                             output int done_c, output int idle_c);
        int cyc;
        mask    = '0;
        nhits   = 0;
        first_v = -1;
        done_c  = -1;
        idle_c  = -1;
        @(negedge clk);
        frame_tick = 1'b1;
        hit_ready  = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        cyc = 1;
        while (idle_c < 0 && cyc < 40) begin
            if (hit_valid) begin
                mask[pair_idx(int'(hit_a), int'(hit_b))] = 1'b1;
                nhits++;
                if (first_v < 0) first_v = cyc;
            end
            if (done && done_c < 0) done_c = cyc;
            if (!busy) idle_c = cyc;
            if (idle_c < 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
    endtask

    initial begin
        logic [5:0] mask;
        int nhits, first_v, done_c, idle_c, lowest, n_seq;
        int seq[8];
        logic stable;

        set_vec(0, px(0, 100, 200, 300),  py(0, 0, 0, 0),       6'b000000, 0);
        set_vec(1, px(10, 40, 400, 800),  py(10, 20, 0, 0),     6'b000001, 1);
        set_vec(2, px(0, 48, 400, 800),   py(0, 0, 0, 0),       6'b000001, 1);
        set_vec(3, px(0, 49, 400, 800),   py(0, 0, 0, 0),       6'b000000, 0);
        set_vec(4, px(0, 0, 400, 800),    py(0, 32, 0, 0),      6'b000001, 1);
        set_vec(5, px(0, 0, 400, 800),    py(0, 33, 0, 0),      6'b000000, 0);
        set_vec(6, px(1000, 0, 400, 700), py(500, 0, 0, 0),     6'b000000, 0);
        set_vec(7, px(60, 12, 400, 800),  py(0, 0, 0, 0),       6'b000001, 1);
        set_vec(8, px(10, 20, 30, 800),   py(10, 10, 10, 300),  6'b001011, 3);
        set_vec(9, px(5, 6, 7, 8),        py(5, 6, 7, 8),       6'b111111, 6);
        set_vec(10, px(0, 200, 400, 420), py(0, 0, 0, 0),      6'b100000, 1);

        pos_x = '0;
        pos_y = '0;
        do_reset();
        #1;
        check("reset_outputs", {24'd0, hit_valid, hit_a, hit_b, busy, done, overrun}, 0);

        // Table-driven single frames, each from a clean reset.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            pos_x = vecs[i].x;
            pos_y = vecs[i].y;
            run_frame(mask, nhits, first_v, done_c, idle_c);
            check($sformatf("vec%0d_mask", i), mask, vecs[i].mask);
            check($sformatf("vec%0d_done_cycle", i), done_c, 7 + vecs[i].hits);
            check($sformatf("vec%0d_idle_cycle", i), idle_c, 8 + vecs[i].hits);
            if (vecs[i].hits > 0) begin
                lowest = 0;
                while (!vecs[i].mask[lowest]) lowest++;
                check($sformatf("vec%0d_first_valid", i), first_v, lowest + 2);
            end
        end

        // Cooldown: static (0,1) overlap, hits in frames 1 and 7 only.
        do_reset();
        pos_x = px(10, 40, 400, 800);
        pos_y = py(10, 20, 0, 0);
        for (int f = 1; f <= 8; f++) begin
            run_frame(mask, nhits, first_v, done_c, idle_c);
            check($sformatf("cooldown_frame%0d", f), mask, (f == 1 || f == 7) ? 1 : 0);
        end

        // Backpressure with a tick during the stall.
        do_reset();
        pos_x = px(10, 20, 30, 800);
        pos_y = py(10, 10, 10, 300);
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check("bp_no_valid_in_test", hit_valid, 0);
        @(posedge clk);
        #1;
        check("bp_valid_rise", {hit_valid, hit_a, hit_b}, {1'b1, 2'd0, 2'd1});
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                @(negedge clk);
                frame_tick = 1'b1;
                @(posedge clk);
                #1;
                frame_tick = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            if (!(hit_valid && hit_a == 2'd0 && hit_b == 2'd1)) stable = 1'b0;
        end
        check("bp_stall_stable", stable, 1);
        check("bp_overrun_set", overrun, 1);
        hit_ready = 1'b1;
        n_seq = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            if (hit_valid && n_seq < 8) begin
                seq[n_seq] = pair_idx(int'(hit_a), int'(hit_b));
                n_seq++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_transfer_count", n_seq, 3);
        check("bp_order0", seq[0], 0);
        check("bp_order1", seq[1], 1);
        check("bp_order2", seq[2], 3);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (busy || hit_valid) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        check("bp_no_rescan", stable, 1);
        check("bp_overrun_sticky", overrun, 1);

        // Reset in the middle of EMIT drops the hit and the cooldown.
        do_reset();
        pos_x = px(10, 40, 400, 800);
        pos_y = py(10, 20, 0, 0);
        hit_ready = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
        check("rst_emit_valid", hit_valid, 1);
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        check("rst_overrun_before", overrun, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_emit_outputs",
              {24'd0, hit_valid, hit_a, hit_b, busy, done, overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(mask, nhits, first_v, done_c, idle_c);
        check("rst_next_frame_mask", mask, 1);
        check("rst_next_frame_first_valid", first_v, 2);
        check("rst_next_frame_overrun", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
